// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: owns the fetch PC, issues reads to a synchronous instruction
// memory and buffers returned words in a DEPTH-entry circular queue for decode.
// Optional feature macro: FETCH_BYPASS_EN. When it is defined, a response that
// arrives while the queue is empty is forwarded combinationally to decode.
module instr_fetch_queue #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  DEPTH    = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                dec_valid,
    input  logic                dec_ready,
    output logic [31:0]         dec_instr,
    output logic [PC_WIDTH-1:0] dec_pc,
    output logic [6:0]          dec_opcode
);
    localparam int          PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W     = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] req_pc;
    logic                inflight;
    logic [31:0]         q_instr [DEPTH];
    logic [PC_WIDTH-1:0] q_pc    [DEPTH];
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr;
    logic [CNT_W-1:0]    count;
    logic                q_empty;
    logic                handshake;
    logic                q_pop;
    logic                push;
    logic [CNT_W:0]      occupancy;
    logic                unused_redirect_lsbs;

    // Redirect targets are forced word-aligned; the two low bits carry no meaning.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Decode-side view: head entry when the queue holds something, else a harmless NOP.
    always_comb begin
        q_empty   = (count == '0);
        dec_valid = !q_empty;
        dec_instr = q_empty ? NOP_INSTR : q_instr[rd_ptr];
        dec_pc    = q_empty ? '0 : q_pc[rd_ptr];
`ifdef FETCH_BYPASS_EN
        if (q_empty && inflight && !redirect_valid) begin
            dec_valid = 1'b1;
            dec_instr = imem_rdata;
            dec_pc    = req_pc;
        end
`endif
        dec_opcode = dec_instr[6:0];
    end

    // Push/pop qualification and the issue rule (in-flight word counts as occupied).
    always_comb begin
        handshake = dec_valid && dec_ready;
        q_pop     = handshake && !q_empty && !redirect_valid;
        push      = inflight && !redirect_valid;
`ifdef FETCH_BYPASS_EN
        // A bypassed word taken by decode this cycle never enters the queue.
        if (q_empty && dec_ready) begin
            push = 1'b0;
        end
`endif
        occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(handshake);
        imem_req  = rst_n && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
        imem_addr = pc;
    end

    // Control state: PC, in-flight flag, queue pointers and count; redirect wins over all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            pc       <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc <= pc + PC_WIDTH'(4);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (q_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(q_pop);
        end
    end

    // Remember the address of the outstanding request so its response can be tagged.
    always_ff @(posedge clk) begin
        if (imem_req) begin
            req_pc <= pc;
        end
    end

    // Queue storage: data only, validity is tracked by the control pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= req_pc;
        end
    end
endmodule
